// File: rtl/demux1_to_4_stream_if.sv
// rtl/demux1_to_4_stream_if.sv - stream and channel signals of the 1-to-4 stream demux
interface demux1_to_4_stream_if #(
  parameter int WIDTH = 32
) ();
  logic               in_valid;
  logic               in_ready;
  logic [1:0]         in_sel;
  logic [WIDTH-1:0]   in_data;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
  logic [7:0]         out_level;

  modport master (
    output in_valid, in_sel, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_level
  );

  modport slave (
    input  in_valid, in_sel, in_data, out_ready,
    output in_ready, out_valid, out_data, out_level
  );
endinterface

// File: rtl/demux1_to_4_stream.sv
// rtl/demux1_to_4_stream.sv - routes one stream to four channels, each behind a 2-entry FIFO
module demux1_to_4_stream #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  demux1_to_4_stream_if.slave  bus
);
  localparam logic [1:0] LEVEL_FULL = 2'd2;

  logic [3:0][1:0]            level_q, level_d;
  logic [3:0]                 wptr_q, wptr_d;
  logic [3:0]                 rptr_q, rptr_d;
  logic [3:0]                 valid_q, valid_d;
  logic [3:0][1:0][WIDTH-1:0] mem_q, mem_d;
  logic [3:0]                 push, pop;
  logic                       in_ready;

  // Readiness looks only at the addressed channel's registered level, so a
  // pop in the same cycle never frees room for the incoming beat.
  assign in_ready     = (level_q[bus.in_sel] != LEVEL_FULL);
  assign bus.in_ready = in_ready;
  assign bus.out_valid = valid_q;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int k = 0; k < 4; k++) begin
      push[k] = bus.in_valid && in_ready && (bus.in_sel == 2'(k));
      pop[k]  = valid_q[k] && bus.out_ready[k];
    end
  end

  always_comb begin
    level_d = level_q;
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    mem_d   = mem_q;
    valid_d = valid_q;
    for (int k = 0; k < 4; k++) begin
      if (push[k]) begin
        mem_d[k][wptr_q[k]] = bus.in_data;
        wptr_d[k]           = ~wptr_q[k];
      end
      if (pop[k]) begin
        rptr_d[k] = ~rptr_q[k];
      end
      case ({push[k], pop[k]})
        2'b10:   level_d[k] = level_q[k] + 2'd1;
        2'b01:   level_d[k] = level_q[k] - 2'd1;
        default: level_d[k] = level_q[k];
      endcase
      valid_d[k] = (level_d[k] != 2'd0);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level_q <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      valid_q <= '0;
      mem_q   <= '0;
    end else begin
      level_q <= level_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      valid_q <= valid_d;
      mem_q   <= mem_d;
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_chan
    assign bus.out_data[g*WIDTH +: WIDTH] = mem_q[g][rptr_q[g]];
    assign bus.out_level[2*g +: 2]        = level_q[g];
  end
endmodule

// File: tb/tb_demux1_to_4_stream.sv
// tb/tb_demux1_to_4_stream.sv - randomized and directed bench for demux1_to_4_stream
module tb_demux1_to_4_stream;
  localparam int W = 32;

  logic clk;
  logic reset_n;
  int   n_checks;
  int   n_fail;
  logic [W-1:0] mq [4][$];

  demux1_to_4_stream_if #(.WIDTH(W)) bus ();

  demux1_to_4_stream #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] chan_data(input int k);
    logic [4*W-1:0] d;
    d = bus.out_data;
    return d[k*W +: W];
  endfunction

  // Reference: one queue per channel; outputs follow from queue sizes and heads.
  always @(negedge clk) begin
    if (!reset_n) begin
      for (int k = 0; k < 4; k++) mq[k].delete();
      chk("rst_out_valid", 128'(bus.out_valid), 128'd0);
      chk("rst_out_level", 128'(bus.out_level), 128'd0);
      chk("rst_out_data", 128'(bus.out_data), 128'd0);
      chk("rst_in_ready", 128'(bus.in_ready), 128'd1);
    end else begin
      logic acc;
      for (int k = 0; k < 4; k++) begin
        chk($sformatf("out_valid%0d", k), 128'(bus.out_valid[k]), 128'(mq[k].size() != 0));
        chk($sformatf("out_level%0d", k), 128'(bus.out_level[2*k +: 2]), 128'(mq[k].size()));
        if (mq[k].size() != 0)
          chk($sformatf("out_data%0d", k), 128'(chan_data(k)), 128'(mq[k][0]));
      end
      chk("in_ready", 128'(bus.in_ready), 128'(mq[bus.in_sel].size() != 2));
      acc = bus.in_valid && (mq[bus.in_sel].size() < 2);
      for (int k = 0; k < 4; k++)
        if (mq[k].size() != 0 && bus.out_ready[k]) void'(mq[k].pop_front());
      if (acc) mq[bus.in_sel].push_back(bus.in_data);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] s, input logic [W-1:0] d);
    bus.in_valid = v;
    bus.in_sel   = s;
    bus.in_data  = d;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    drive(1'b0, 2'd0, '0);
    bus.out_ready = 4'h0;
    #1;
    chk("init_in_ready", 128'(bus.in_ready), 128'd1);
    chk("init_out_level", 128'(bus.out_level), 128'd0);
    step();
    reset_n = 1'b1;

    // Routing: each beat visible on its own channel one cycle after acceptance.
    bus.out_ready = 4'hf;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 2'(i), W'(32'hA0 + i));
      #1;
      chk("route_in_ready", 128'(bus.in_ready), 128'd1);
      step();
      chk("route_valid", 128'(bus.out_valid), 128'(4'b0001 << i));
      chk("route_data", 128'(chan_data(i)), 128'(32'hA0 + i));
    end
    drive(1'b0, 2'd0, '0);
    step();
    chk("route_idle", 128'(bus.out_valid), 128'd0);

    // Fill/stall on channel 2.
    bus.out_ready = 4'b1011;
    drive(1'b1, 2'd2, 32'h11);
    step();
    drive(1'b1, 2'd2, 32'h22);
    step();
    chk("fill_level2", 128'(bus.out_level[5:4]), 128'd2);
    drive(1'b1, 2'd2, 32'h33);
    #1;
    chk("fill_stall", 128'(bus.in_ready), 128'd0);
    step();
    chk("fill_hold_level", 128'(bus.out_level[5:4]), 128'd2);
    bus.out_ready = 4'hf;
    #1;
    chk("fill_pop_head", 128'(chan_data(2)), 128'h11);
    chk("fill_pop_stall", 128'(bus.in_ready), 128'd0);
    step();
    bus.out_ready = 4'b1011;
    chk("fill_after_pop_level", 128'(bus.out_level[5:4]), 128'd1);
    chk("fill_after_pop_head", 128'(chan_data(2)), 128'h22);
    #1;
    chk("fill_ready_again", 128'(bus.in_ready), 128'd1);
    step();
    chk("fill_33_level", 128'(bus.out_level[5:4]), 128'd2);
    drive(1'b0, 2'd0, '0);
    bus.out_ready = 4'hf;
    step();
    chk("fill_order_33", 128'(chan_data(2)), 128'h33);
    step();
    chk("fill_empty", 128'(bus.out_level[5:4]), 128'd0);

    // Push and pop together at level 1 on channel 1, wrapping the pointers.
    bus.out_ready = 4'h0;
    drive(1'b1, 2'd1, 32'h5);
    step();
    for (int v = 6; v < 10; v++) begin
      drive(1'b1, 2'd1, W'(v));
      bus.out_ready = 4'b0010;
      step();
      chk("pp_level", 128'(bus.out_level[3:2]), 128'd1);
      chk("pp_head", 128'(chan_data(1)), 128'(v));
    end
    drive(1'b0, 2'd0, '0);
    step();
    chk("pp_empty", 128'(bus.out_level[3:2]), 128'd0);

    // Head-of-line: full channel 3, then retarget the held beat to channel 0.
    bus.out_ready = 4'h0;
    drive(1'b1, 2'd3, 32'h31);
    step();
    drive(1'b1, 2'd3, 32'h32);
    step();
    drive(1'b1, 2'd3, 32'h40);
    #1;
    chk("hol_stall", 128'(bus.in_ready), 128'd0);
    step();
    chk("hol_level3", 128'(bus.out_level[7:6]), 128'd2);
    bus.in_sel = 2'd0;
    #1;
    chk("hol_ready", 128'(bus.in_ready), 128'd1);
    step();
    chk("hol_ch0_valid", 128'(bus.out_valid[0]), 128'd1);
    chk("hol_ch0_data", 128'(chan_data(0)), 128'h40);
    chk("hol_ch3_head", 128'(chan_data(3)), 128'h31);

    // Reset mid-stream with channels 0 and 3 holding beats.
    drive(1'b1, 2'd1, 32'h77);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_valid", 128'(bus.out_valid), 128'd0);
    chk("mid_rst_level", 128'(bus.out_level), 128'd0);
    chk("mid_rst_data", 128'(bus.out_data), 128'd0);
    chk("mid_rst_ready", 128'(bus.in_ready), 128'd1);
    step();
    reset_n = 1'b1;
    drive(1'b0, 2'd0, '0);
    step();

    // Random soak against the per-channel queues.
    for (int c = 0; c < 10000; c++) begin
      drive(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)), W'($urandom));
      bus.out_ready = 4'($urandom) & 4'($urandom | 32'($urandom_range(0, 1) * 15));
      step();
    end
    drive(1'b0, 2'd0, '0);
    bus.out_ready = 4'hf;
    step();
    step();
    step();
    chk("drain_level", 128'(bus.out_level), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
